// File: rtl/slab_pkg.sv
// slab_pkg: shared constants for the ray/box slab-reduction sequencer.
// 16-bit FP layout, exception codes, FSM state codes and defaults.
package slab_pkg;

    localparam int FP_W     = 16;
    localparam int EXC_HI   = 15;
    localparam int EXC_LO   = 14;
    localparam int SIGN_BIT = 13;
    localparam int EXP_HI   = 12;
    localparam int EXP_LO   = 11;
    localparam int FRAC_HI  = 10;

    localparam logic [1:0] EXC_ZERO = 2'b00;
    localparam logic [1:0] EXC_NORM = 2'b01;
    localparam logic [1:0] EXC_INF  = 2'b10;
    localparam logic [1:0] EXC_NAN  = 2'b11;

    localparam logic [FP_W-1:0] ZERO_FP = 16'h0000;

    localparam int CMP_LAT_DEF = 3;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_N1   = 3'd1;
    localparam logic [2:0] S_N2   = 3'd2;
    localparam logic [2:0] S_F1   = 3'd3;
    localparam logic [2:0] S_F2   = 3'd4;
    localparam logic [2:0] S_X    = 3'd5;
    localparam logic [2:0] S_Z    = 3'd6;
    localparam logic [2:0] S_DONE = 3'd7;

    function automatic logic is_nan(input logic [FP_W-1:0] w);
        return w[EXC_HI:EXC_LO] == EXC_NAN;
    endfunction

endpackage

// File: rtl/slab_cmp_timer.sv
// slab_cmp_timer: 0..CMP_LAT wait counter for one comparator round.
// strobe marks the cycle whose closing edge samples cmp_less.
module slab_cmp_timer
    import slab_pkg::*;
#(
    parameter int CMP_LAT = CMP_LAT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic strobe
);

    localparam int CW = (CMP_LAT < 1) ? 1 : $clog2(CMP_LAT + 1);
    localparam logic [CW-1:0] LAST = CW'(CMP_LAT);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (run && cnt != LAST) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign strobe = run && (cnt == LAST);

endmodule

// File: rtl/slab_interval_seq.sv
// slab_interval_seq: reduces six slab distances to tmin/tmax through one
// shared external comparator and reports the ray/box hit decision.
module slab_interval_seq
    import slab_pkg::*;
#(
    parameter int WIDTH   = FP_W,
    parameter int CMP_LAT = CMP_LAT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3*WIDTH-1:0] t_near,
    input  logic [3*WIDTH-1:0] t_far,
    output logic [WIDTH-1:0]   cmp_a,
    output logic [WIDTH-1:0]   cmp_b,
    input  logic               cmp_less,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               hit,
    output logic               nan_flag
);

    logic [2:0]       state;
    logic [WIDTH-1:0] tnz, tfy, tfz, tmin, tmax;
    logic [WIDTH-1:0] nx, ny, nz, fx, fy, fz;
    logic [WIDTH-1:0] tmin_n, tmax_n;
    logic             miss_x, strobe, accept, run, any_nan;

    assign nx = t_near[WIDTH-1:0];
    assign ny = t_near[2*WIDTH-1:WIDTH];
    assign nz = t_near[3*WIDTH-1:2*WIDTH];
    assign fx = t_far[WIDTH-1:0];
    assign fy = t_far[2*WIDTH-1:WIDTH];
    assign fz = t_far[3*WIDTH-1:2*WIDTH];

    assign accept  = in_valid && in_ready;
    assign run     = (state != S_IDLE) && (state != S_DONE);
    assign any_nan = is_nan(nx) || is_nan(ny) || is_nan(nz)
                  || is_nan(fx) || is_nan(fy) || is_nan(fz);

    // Near rounds put the candidate on B, far rounds put it on A.
    assign tmin_n = cmp_less ? cmp_b : tmin;
    assign tmax_n = cmp_less ? cmp_a : tmax;

    slab_cmp_timer #(.CMP_LAT(CMP_LAT)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .run    (run),
        .clr    (accept || strobe),
        .strobe (strobe)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            hit       <= 1'b0;
            nan_flag  <= 1'b0;
            cmp_a     <= '0;
            cmp_b     <= '0;
            tnz       <= '0;
            tfy       <= '0;
            tfz       <= '0;
            tmin      <= '0;
            tmax      <= '0;
            miss_x    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: if (accept) begin
                    in_ready <= 1'b0;
                    tnz      <= nz;
                    tfy      <= fy;
                    tfz      <= fz;
                    tmin     <= nx;
                    tmax     <= fx;
                    if (any_nan) begin
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                        hit       <= 1'b0;
                        nan_flag  <= 1'b1;
                    end else begin
                        state <= S_N1;
                        cmp_a <= nx;
                        cmp_b <= ny;
                    end
                end
                S_N1: if (strobe) begin
                    tmin  <= tmin_n;
                    cmp_a <= tmin_n;
                    cmp_b <= tnz;
                    state <= S_N2;
                end
                S_N2: if (strobe) begin
                    tmin  <= tmin_n;
                    cmp_a <= tfy;
                    cmp_b <= tmax;
                    state <= S_F1;
                end
                S_F1: if (strobe) begin
                    tmax  <= tmax_n;
                    cmp_a <= tfz;
                    cmp_b <= tmax_n;
                    state <= S_F2;
                end
                S_F2: if (strobe) begin
                    tmax  <= tmax_n;
                    cmp_a <= tmax_n;
                    cmp_b <= tmin;
                    state <= S_X;
                end
                S_X: if (strobe) begin
                    miss_x <= cmp_less;
                    cmp_a  <= tmax;
                    cmp_b  <= ZERO_FP;
                    state  <= S_Z;
                end
                S_Z: if (strobe) begin
                    hit       <= !miss_x && !cmp_less;
                    nan_flag  <= 1'b0;
                    out_valid <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/slab_interval_seq.md
Name: slab_interval_seq

Overview:
- Ray/AABB slab-reduction sequencer for the 16-bit FP (wE=2, wF=11) datapath. It sits directly upstream of and around the less_than comparator stage.
- Accepts six slab distances per ray/box pair: t_near x/y/z and t_far x/y/z.
- Time-multiplexes one external comparator to compute tmin = max(t_near) and tmax = min(t_far).
- Emits hit = (tmin <= tmax) && (tmax >= 0) through a valid/ready handshake.

Parameters:
- WIDTH, 16, FP word width: [15:14] exception, [13] sign, [12:11] exponent, [10:0] fraction.
- CMP_LAT, 3, cycles from operands driven on cmp_a/cmp_b until cmp_less is valid (FPSub depth + 1 output register).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- in_valid  in  1  six-operand bundle valid
- in_ready  out  1  block can accept a bundle
- t_near  in  3*WIDTH  {z,y,x} near distances, x in LSBs
- t_far  in  3*WIDTH  {z,y,x} far distances, x in LSBs
- cmp_a  out  WIDTH  comparator operand A
- cmp_b  out  WIDTH  comparator operand B
- cmp_less  in  1  comparator result: A < B, normal result only
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- hit  out  1  ray intersects box
- nan_flag  out  1  an input carried exception code 2'b11

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; in_ready=1; out_valid=0; hit=0; nan_flag=0; cmp_a=cmp_b=0; wait counter=0.
  - Reset mid-sequence aborts the bundle with no output.
- All outputs are registered.
- Accept: in_valid && in_ready at edge c0.
  - The six operands are latched.
  - in_ready drops at the next edge and stays 0 until the result handshake completes.
  - in_ready is 1 only in IDLE.
- NaN shortcut: if any latched exception field is 2'b11, go to DONE.
  - out_valid=1, hit=0, nan_flag=1 are visible the cycle after accept.
  - No comparisons are issued.
- States: IDLE -> N1 -> N2 -> F1 -> F2 -> X -> Z -> DONE -> IDLE.
- Each compare state has the same timing:
  - Drive cmp_a/cmp_b in its first cycle and hold them stable for CMP_LAT+1 cycles.
  - Sample cmp_less at the edge ending cycle CMP_LAT after the drive cycle.
  - Move to the next state on that edge.
  - Wait counter: 0..CMP_LAT, cleared on each state entry.
- Compare sequence (tmin init = tnx, tmax init = tfx at accept):
  - N1: A=tmin, B=tny; less -> tmin=tny.
  - N2: A=tmin, B=tnz; less -> tmin=tnz.
  - F1: A=tfy, B=tmax; less -> tmax=tfy.
  - F2: A=tfz, B=tmax; less -> tmax=tfz.
  - X: A=tmax, B=tmin; less -> miss_x=1.
  - Z: A=tmax, B=ZERO (16'h0000); less -> miss_z=1.
- Ties:
  - Equal operands give a zero result with exception 00, so less=0. Ties keep the current value.
  - tmin==tmax counts as a hit; tmax==0 counts as a hit.
  - A difference with an inf/zero exception reads less=0. This is accepted as the defined behaviour.
- DONE:
  - out_valid=1, hit = !miss_x && !miss_z, nan_flag=0.
  - Hold all result outputs stable while out_ready=0.
  - On out_valid && out_ready: out_valid=0 and in_ready=1 at the next edge.
- Latency: accept at edge c0 -> out_valid high from cycle c0+1+6*(CMP_LAT+1). With CMP_LAT=3 that is c0+25.
- Throughput: one bundle in flight. There is no input buffering; the next accept comes no earlier than the edge after the result handshake.
- Operands and cmp_less are ignored in IDLE and DONE. cmp_a/cmp_b keep their last values there.

Decomposition:
- Shared package (slab_pkg):
  - FP field positions and exception codes EXC_ZERO=2'b00, EXC_NORM=2'b01, EXC_INF=2'b10, EXC_NAN=2'b11.
  - ZERO_FP=16'h0000.
  - State encoding localparams.
  - Default CMP_LAT.
- Sub-module slab_cmp_timer: loadable 0..CMP_LAT counter producing a sample strobe.
- The comparator stays external, instantiated beside this block by the parent.

Test Plan:
- Bench comparator model: a behavioural compare with CMP_LAT delay, less only for a normal negative A-B.
- Hit: near={4C00,4800,4000}, far={5000,5000,5400} (z..x).
  - Required: tmin=4C00 (1.5), tmax=5000 (2.0), hit=1, nan_flag=0.
  - out_valid rises exactly 25 cycles after accept.
- Miss: near={4000,4000,5000}, far={5400,4800,5400}.
  - Required: tmin=2.0, tmax=1.0, hit=0.
- Behind origin: near={6800,6800,6800}, far={6800,6800,6800} (all -1.0).
  - Required: miss_z path, hit=0.
  - Variant with near all -1.0 and far all 0x0000: hit=1 (tmax==0 tie).
- NaN: tfy=C000, all other operands 4800.
  - Required: out_valid the cycle after accept, hit=0, nan_flag=1, cmp_a/cmp_b never change.
- Backpressure and reset:
  - Hold out_ready=0 for 10 cycles: outputs stable and in_ready=0 throughout.
  - Assert rst low during state F1: in_ready=1 and out_valid=0 immediately. A fresh bundle then completes normally.
